// File: rtl/axis_y_transpose.sv
// axis_y_transpose: receives systolic-array output tiles column by column,
// requantizes every accumulator word and re-emits the tile row by row.
// A ping-pong pair of tile banks lets one tile fill while the other drains.
// Optional feature: define AXIS_Y_REQUANT_SAT_EN to saturate narrowed words
// instead of keeping their low WO bits (wrap).
`timescale 1ns/1ps
module axis_y_transpose #(
    parameter int R     = 2,
    parameter int C     = 2,
    parameter int WY    = 16,
    parameter int WO    = 8,
    parameter int SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [R-1:0][WY-1:0]  s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [C-1:0][WO-1:0]  m_data,
    output logic                  s_err
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam int NW = $clog2(C + 1);

    // Tile storage: mem_q[bank][column][row]
    logic [WY-1:0] mem_q [2][C][R];

    // Write-side control
    logic          wb_q, wb_d;
    logic [CW-1:0] wc_q, wc_d;
    logic [1:0]    full_q, full_d;
    logic [NW-1:0] ncols_q [2];
    logic [NW-1:0] ncols_d [2];
    logic          err_q, err_d;

    // Read-side control and output registers
    logic          rb_q, rb_d;
    logic [RW-1:0] rr_q, rr_d;
    logic          mv_q, mv_d;
    logic          ml_q, ml_d;
    logic [C-1:0][WO-1:0] md_q, md_d;
    logic [C-1:0][WO-1:0] row_w;

    logic wr_hs;
    logic wr_close;
    logic rd_load;
    logic rd_last_row;

    // Arithmetic shift (floor toward -inf) followed by narrowing to WO bits
    function automatic logic [WO-1:0] requant(input logic [WY-1:0] y);
        logic signed [WY-1:0] v;
`ifdef AXIS_Y_REQUANT_SAT_EN
        logic signed [WY-1:0] qmax;
        logic signed [WY-1:0] qmin;
        qmax = WY'((2 ** (WO - 1)) - 1);
        qmin = ~qmax;
`endif
        v = $signed(y) >>> SHIFT;
`ifdef AXIS_Y_REQUANT_SAT_EN
        if (v > qmax) begin
            v = qmax;
        end else if (v < qmin) begin
            v = qmin;
        end
`endif
        return v[WO-1:0];
    endfunction

    assign s_ready     = !full_q[wb_q];
    assign wr_hs       = s_valid && s_ready;
    assign wr_close    = (wc_q == CW'(C - 1)) || s_last;
    assign rd_load     = (!mv_q || m_ready) && full_q[rb_q];
    assign rd_last_row = (rr_q == RW'(R - 1));

    assign m_valid = mv_q;
    assign m_last  = ml_q;
    assign m_data  = md_q;
    assign s_err   = err_q;

    // Gather row rr of the draining bank; columns never written read as zero
    always_comb begin
        row_w = '0;
        for (int c = 0; c < C; c++) begin
            if (NW'(c) < ncols_q[rb_q]) begin
                row_w[c] = requant(mem_q[rb_q][c][rr_q]);
            end
        end
    end

    // Next-state for both sides; the two sides only ever touch different banks
    always_comb begin
        wb_d    = wb_q;
        wc_d    = wc_q;
        full_d  = full_q;
        ncols_d = ncols_q;
        err_d   = err_q;
        rb_d    = rb_q;
        rr_d    = rr_q;
        mv_d    = mv_q;
        ml_d    = ml_q;
        md_d    = md_q;

        if (wr_hs) begin
            if (s_last && (wc_q != CW'(C - 1))) begin
                err_d = 1'b1;
            end
            if (!s_last && (wc_q == CW'(C - 1))) begin
                err_d = 1'b1;
            end
            if (wr_close) begin
                full_d[wb_q]  = 1'b1;
                ncols_d[wb_q] = NW'(wc_q) + NW'(1);
                wc_d          = '0;
                wb_d          = ~wb_q;
            end else begin
                wc_d = wc_q + CW'(1);
            end
        end

        if (rd_load) begin
            mv_d = 1'b1;
            ml_d = rd_last_row;
            md_d = row_w;
            if (rd_last_row) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                rr_d         = '0;
            end else begin
                rr_d = rr_q + RW'(1);
            end
        end else if (mv_q && m_ready) begin
            mv_d = 1'b0;
        end
    end

    // Bank write on every accepted column; data storage needs no reset
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            for (int r = 0; r < R; r++) begin
                mem_q[wb_q][wc_q][r] <= s_data[r];
            end
        end
    end

    // Control and output registers; reset discards both banks
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_q       <= 1'b0;
            wc_q       <= '0;
            full_q     <= '0;
            ncols_q[0] <= '0;
            ncols_q[1] <= '0;
            err_q      <= 1'b0;
            rb_q       <= 1'b0;
            rr_q       <= '0;
            mv_q       <= 1'b0;
            ml_q       <= 1'b0;
            md_q       <= '0;
        end else begin
            wb_q       <= wb_d;
            wc_q       <= wc_d;
            full_q     <= full_d;
            ncols_q[0] <= ncols_d[0];
            ncols_q[1] <= ncols_d[1];
            err_q      <= err_d;
            rb_q       <= rb_d;
            rr_q       <= rr_d;
            mv_q       <= mv_d;
            ml_q       <= ml_d;
            md_q       <= md_d;
        end
    end

endmodule

// File: tb/tb_axis_y_transpose.sv
// Testbench for axis_y_transpose: table-driven single-tile vectors, directed
// multi-cycle sequences and a randomized run against a tile-level model.
`timescale 1ns/1ps
module tb_axis_y_transpose;

    localparam int R = 2, C = 2, WY = 16, WO = 8, SHIFT = 4;
    localparam int NRAND = 300;

    logic clk = 1'b0;
    logic rstn;
    logic s_valid, s_ready, s_last;
    logic [R-1:0][WY-1:0] s_data;
    logic m_valid, m_ready, m_last;
    logic [C-1:0][WO-1:0] m_data;
    logic s_err;

    int nvec = 0;
    int nerr = 0;

    axis_y_transpose #(.R(R), .C(C), .WY(WY), .WO(WO), .SHIFT(SHIFT)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
        .s_err(s_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c0r0, c0r1, c1r0, c1r1;
        int l0, l1, nbeats;
        int r0c0, r0c1, r1c0, r1c1;
        int err;
    } vec_t;

    typedef struct {
        logic [C*WO-1:0] d;
        logic            l;
    } ob_t;

    vec_t vt[6];
    ob_t  expq[$];
    int   cur[C][R];
    int   mcnt;
    bit   merr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference requantizer: floor shift, then wrap or clamp to WO bits
    function automatic logic [WO-1:0] q(input int y);
        int v;
        v = y >>> SHIFT;
`ifdef AXIS_Y_REQUANT_SAT_EN
        if (v > (2 ** (WO - 1)) - 1) v = (2 ** (WO - 1)) - 1;
        if (v < -(2 ** (WO - 1))) v = -(2 ** (WO - 1));
`endif
        return WO'(v);
    endfunction

    // Tile-level model: collect columns, emit R rows when the tile closes
    task automatic model_in();
        bit closing;
        logic [C*WO-1:0] d;
        ob_t o;
        closing = (mcnt == C - 1) || s_last;
        if (s_last && mcnt < C - 1) merr = 1'b1;
        if (!s_last && mcnt == C - 1) merr = 1'b1;
        for (int r = 0; r < R; r++) cur[mcnt][r] = int'($signed(s_data[r]));
        mcnt++;
        if (closing) begin
            for (int r = 0; r < R; r++) begin
                d = '0;
                for (int c = 0; c < C; c++)
                    if (c < mcnt) d[c*WO +: WO] = q(cur[c][r]);
                o.d = d;
                o.l = (r == R - 1);
                expq.push_back(o);
            end
            mcnt = 0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_col(input int a0, input int a1, input logic last);
        bit ok;
        ok = 1'b0;
        s_data[0] = 16'(a0);
        s_data[1] = 16'(a1);
        s_last = last;
        s_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic get_beat(output logic [C*WO-1:0] d, output logic l);
        bit ok;
        ok = 1'b0;
        d = '0;
        l = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                ok = 1'b1;
                d = m_data;
                l = m_last;
            end
            @(posedge clk);
            #1;
        end
        chk("beat_received", 32'(ok), 32'd1);
    endtask

    task automatic chk_row(input string nm, input int c0, input int c1, input int lst);
        logic [C*WO-1:0] d;
        logic l;
        get_beat(d, l);
        chk({nm, "_data"}, 32'(d), 32'({8'(c1), 8'(c0)}));
        chk({nm, "_last"}, 32'(l), 32'(lst));
    endtask

    initial begin
        logic [C*WO-1:0] d;
        logic l;
        int nout, first, idx, stale;
        bit hs, done, prev_stall, prev_l;
        logic [C*WO-1:0] prev_d;
        int bpos, sent;
        ob_t e;

        // col values, lasts, beats, expected rows, error
        vt[0] = '{160, -48, 32, 16, 0, 1, 2, 10, 2, -3, 1, 0};
`ifdef AXIS_Y_REQUANT_SAT_EN
        vt[1] = '{4000, -4000, 0, 0, 0, 1, 2, 127, 0, -128, 0, 0};
        vt[5] = '{2047, -2048, 2048, -2049, 0, 1, 2, 127, 127, -128, -128, 0};
`else
        vt[1] = '{4000, -4000, 0, 0, 0, 1, 2, -6, 0, 6, 0, 0};
        vt[5] = '{2047, -2048, 2048, -2049, 0, 1, 2, 127, -128, -128, 127, 0};
`endif
        vt[2] = '{-1, -17, 15, 17, 0, 1, 2, -1, 0, -2, 1, 0};
        vt[3] = '{64, -64, 0, 0, 1, 0, 1, 4, 0, -4, 0, 1};
        vt[4] = '{48, 32, 80, -80, 0, 0, 2, 3, 5, 2, -5, 1};

        // Reset state while reset is held
        rstn = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        #2;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_s_err", 32'(s_err), 32'd0);

        // Table-driven single tiles
        for (int i = 0; i < 6; i++) begin
            do_reset();
            m_ready = 1'b1;
            send_col(vt[i].c0r0, vt[i].c0r1, 1'(vt[i].l0));
            if (vt[i].nbeats == 2) send_col(vt[i].c1r0, vt[i].c1r1, 1'(vt[i].l1));
            chk_row($sformatf("vec%0d_row0", i), vt[i].r0c0, vt[i].r0c1, 0);
            chk_row($sformatf("vec%0d_row1", i), vt[i].r1c0, vt[i].r1c1, 1);
            chk($sformatf("vec%0d_s_err", i), 32'(s_err), 32'(vt[i].err));
        end

        // Three back-to-back tiles at full rate
        do_reset();
        m_ready = 1'b1;
        idx = 0;
        nout = 0;
        first = 0;
        s_valid = 1'b1;
        for (int r = 0; r < R; r++) s_data[r] = 16'(16 * (r + 1));
        s_last = 1'b0;
        for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
            @(negedge clk);
            if (s_valid) chk("b2b_s_ready", 32'(s_ready), 32'd1);
            hs = s_valid && s_ready;
            if (m_valid) begin
                chk("b2b_data", 32'(m_data),
                    32'({8'(10 * (nout / 2) + 3 + nout % 2), 8'(10 * (nout / 2) + 1 + nout % 2)}));
                chk("b2b_last", 32'(m_last), 32'(nout % 2));
                if (nout == 0) first = cyc;
                else chk("b2b_no_bubble", 32'(cyc), 32'(first + nout));
                nout++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (idx < 6) begin
                    for (int r = 0; r < R; r++)
                        s_data[r] = 16'(16 * (10 * (idx / 2) + 2 * (idx % 2) + r + 1));
                    s_last = 1'(idx % 2);
                end else begin
                    s_valid = 1'b0;
                    s_last = 1'b0;
                end
            end
        end
        chk("b2b_count", 32'(nout), 32'd6);

        // Backpressure: two tiles fill both banks
        do_reset();
        m_ready = 1'b0;
        send_col(160, -48, 1'b0);
        send_col(32, 16, 1'b1);
        send_col(16, 32, 1'b0);
        send_col(48, 64, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_hold_data", 32'({m_last, m_data}), 32'({1'b0, 8'd2, 8'd10}));
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        chk_row("bp_t0r0", 10, 2, 0);
        chk_row("bp_t0r1", -3, 1, 1);
        chk_row("bp_t1r0", 1, 3, 0);
        chk_row("bp_t1r1", 2, 4, 1);

        // Reset in the middle of a drain
        do_reset();
        m_ready = 1'b0;
        send_col(160, -48, 1'b0);
        send_col(32, 16, 1'b1);
        hs = 1'b0;
        for (int i = 0; i < 10 && !hs; i++) begin
            @(negedge clk);
            hs = m_valid;
        end
        chk("rd_valid_before", 32'(m_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rd_m_valid_now", 32'(m_valid), 32'd0);
        chk("rd_m_data_now", 32'(m_data), 32'd0);
        chk("rd_s_ready_now", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1 rstn = 1'b1;
        m_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) stale++;
        end
        chk("rd_no_stale", 32'(stale), 32'd0);
        chk("rd_s_ready_after", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Randomized traffic against the tile model
        do_reset();
        merr = 1'b0;
        mcnt = 0;
        expq.delete();
        sent = 0;
        bpos = 0;
        hs = 1'b0;
        done = 1'b0;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            if (hs) begin
                s_valid = 1'b0;
                s_last = 1'b0;
            end
            if (!s_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
                for (int r = 0; r < R; r++) s_data[r] = 16'($urandom);
                s_last = 1'(bpos == C - 1);
                if ($urandom_range(0, 9) == 0) s_last = ~s_last;
                if (sent == NRAND - 1) s_last = 1'b1;
                s_valid = 1'b1;
            end
            m_ready = 1'($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (prev_stall) begin
                chk("rand_hold_valid", 32'(m_valid), 32'd1);
                chk("rand_hold_data", 32'({m_last, m_data}), 32'({prev_l, prev_d}));
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rand_extra_beat: got data %0h, expected no beat", m_data);
                end else begin
                    e = expq.pop_front();
                    chk("rand_data", 32'(m_data), 32'(e.d));
                    chk("rand_last", 32'(m_last), 32'(e.l));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            hs = s_valid && s_ready;
            if (hs) begin
                model_in();
                bpos = (s_last || bpos == C - 1) ? 0 : bpos + 1;
                sent++;
            end
            done = (sent == NRAND) && (expq.size() == 0);
            @(posedge clk);
            #1;
        end
        chk("rand_completed", 32'(done), 32'd1);
        chk("rand_s_err", 32'(s_err), 32'(merr));
        s_valid = 1'b0;
        m_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_valid) stale++;
        end
        chk("rand_no_extra", 32'(stale), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/axis_y_transpose.md
# axis_y_transpose

Receiving end of the systolic array output stream. It accepts output tiles column by column: C beats, each carrying R accumulator words of WY bits, with `s_last` on the final column. It requantizes every word to WO bits and re-emits the tile row by row: R beats, each carrying C words, with `m_last` on the final row. A ping-pong pair of tile banks lets the next tile fill while the previous one drains, so a continuous stream runs at full rate on both sides.

## Interface
- R, 2, rows of the array; words per input beat and number of output beats
- C, 2, columns of the array; input beats per tile and words per output beat
- WY, 16, signed accumulator word width on the input
- WO, 8, signed word width on the output
- SHIFT, 4, arithmetic right shift applied before narrowing
- clk  in  1  clock; the only clock
- rstn  in  1  reset, asynchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when high with s_valid
- s_last  in  1  marks the last column of a tile
- s_data  in  [R-1:0][WY-1:0]  one column; s_data[r] is row r
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_last  out  1  marks the last row of a tile
- m_data  out  [C-1:0][WO-1:0]  one row; m_data[c] is column c
- s_err  out  1  sticky tile-framing error flag

## Operation
- Storage: two banks, each holding C×R words of WY bits.
- Write side state:
  - wb: bank being filled
  - wc: column counter, 0..C-1
  - full[2]: bank-full flags
  - ncols[2]: number of columns stored per bank
- `s_ready` = !full[wb], combinational.
- On each input handshake:
  - Store s_data[r] into bank[wb][wc][r].
  - If wc==C-1 or s_last: set full[wb], ncols[wb]=wc+1, wc=0, toggle wb. Otherwise wc++.
- Framing errors set `s_err`. `s_err` clears only on reset.
  - s_last high with wc<C-1 (early close). The tile still closes, and the missing columns read as 0.
  - s_last low with wc==C-1. The tile still closes, and the next beat starts a new tile.
- Read side state:
  - rb: bank being drained
  - rr: row counter, 0..R-1
- Output register loads when (!m_valid || m_ready) and full[rb]:
  - m_data[c] = Q(bank[rb][c][rr]) for c<ncols[rb], otherwise 0.
  - m_last = (rr==R-1).
  - On the rr==R-1 load, clear full[rb], toggle rb, and set rr=0. Otherwise rr++.
  - If no bank is full, a completed handshake drops m_valid.
- Requantization Q(y):
  - v = y >>> SHIFT: arithmetic shift, floor toward −∞.
  - Narrow v to WO bits as set by Configuration.
- Reset, including mid-operation: both banks are discarded.
  - full=0, wb=rb=0, wc=rr=0.
  - m_valid=0, m_last=0, m_data=0, s_err=0.
  - s_ready=1 as soon as reset is applied.

## Timing
- Output registers (`m_valid`, `m_last`, `m_data`) are flopped and held stable while m_valid && !m_ready.
- Latency: if a tile's last input handshake is at edge t, its first output beat is valid after edge t+1.
- Throughput: one beat per cycle on each side. With m_ready=1 and C≥R, a continuous input stream sees s_ready stuck at 1.
- A bank released at edge t is visible to `s_ready` from the cycle after t. No same-cycle bypass from release to s_ready.
- Simultaneous fill and drain of different banks in the same cycle are independent.
- With both banks full and m_ready=0, s_ready=0 until a bank is released.

## Configuration
- `AXIS_Y_REQUANT_SAT_EN` defined: v saturates to [−2^(WO−1), 2^(WO−1)−1].
- Not defined: Q keeps the low WO bits of v, so out-of-range values wrap.

## Test plan
All scenarios use the default parameters R=2, C=2, WY=16, WO=8, SHIFT=4.
- Single tile, m_ready=1. Input col0 {r0=160, r1=−48}, then col1 {r0=32, r1=16} with s_last. Required: row0 m_data={c0=10, c1=2}; row1 {−3, 1} with m_last; s_err=0.
- Narrowing. col0 {4000, −4000}, col1 {0, 0}. With the macro: row0 c0=127, row1 c0=−128. Without it: 0xFA (−6) and 0x06 (6).
- Three back-to-back tiles, s_valid=1 and m_ready=1 throughout. Required: s_ready never drops; outputs arrive in order with no bubble after the first beat; m_last on every second output beat.
- Backpressure. m_ready=0 while sending 2 tiles (4 beats). Required: s_ready=0 after the 4th handshake; m_data for row0 of tile 0 stays stable. Then m_ready=1: 4 output beats, tile 0 then tile 1.
- Framing errors. s_last on the first beat: s_err=1, and both output rows have c1=0. Separately, a tile with no s_last: it closes after 2 beats and s_err=1.
- Reset mid-drain. Pull rstn low while row0 is valid. Required: m_valid=0 immediately; after release s_ready=1 and no stale beats are emitted.
